// File: rtl/bus_reg_bank_pkg.sv
// bus_reg_bank_pkg: shared sizes, FSM encoding and clear bounds for the bus register bank.
// BUS_REG_BANK_R0_ZERO_EN makes register 0 constant zero and starts the clear at index 1.
package bus_reg_bank_pkg;
    localparam int NUM_REGS = 32;
    localparam int REG_W = 32;
    localparam int SEL_W = 5;
    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;
    localparam logic [SEL_W-1:0] CLR_LAST = 5'd31;
`ifdef BUS_REG_BANK_R0_ZERO_EN
    localparam bit R0_ZERO = 1'b1;
    localparam logic [SEL_W-1:0] CLR_FIRST = 5'd1;
`else
    localparam bit R0_ZERO = 1'b0;
    localparam logic [SEL_W-1:0] CLR_FIRST = 5'd0;
`endif
endpackage

// File: rtl/bus_reg_bank_reg_load32.sv
// reg_load32: bus-width register with async active-high reset and load enable.
module reg_load32
    import bus_reg_bank_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [REG_W-1:0] d,
    output logic [REG_W-1:0] q
);
    always_ff @(posedge clock or posedge reset)
        if (reset) q <= '0;
        else if (load) q <= d;
endmodule

// File: rtl/bus_reg_bank.sv
// bus_reg_bank: 32-register bus write bank with parallel readout and sequenced bank clear.
// BUS_REG_BANK_R0_ZERO_EN ties register 0 to zero (writes to it are acked and discarded).
module bus_reg_bank #(
    parameter int NUM_REGS = bus_reg_bank_pkg::NUM_REGS,
    parameter int REG_W = bus_reg_bank_pkg::REG_W
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [4:0]                wr_sel,
    input  logic [REG_W-1:0]          wr_data,
    output logic                      wr_ready,
    output logic                      wr_ack,
    input  logic                      clr_req,
    output logic                      clr_busy,
    output logic                      clr_done,
    output logic [NUM_REGS*REG_W-1:0] regs_flat
);
    import bus_reg_bank_pkg::*;
    state_t state, state_n;
    logic [SEL_W-1:0] clr_idx, clr_idx_n;
    logic accept, last;
    logic [NUM_REGS-1:0] wr_hot, clr_hot, ld;
    logic [REG_W-1:0] ld_data;
    assign clr_busy = state == CLEAR;
    assign wr_ready = !clr_busy;
    assign accept = wr_en && wr_ready;
    assign last = clr_idx == CLR_LAST;
    assign ld = wr_hot | clr_hot;
    // Writes never overlap a clear, so the load data only needs the clear override.
    assign ld_data = clr_busy ? '0 : wr_data;
    always_comb begin
        state_n = state;
        clr_idx_n = clr_idx;
        state_n = clr_busy ? (last ? IDLE : CLEAR) : (clr_req ? CLEAR : IDLE);
        clr_idx_n = clr_busy ? (last ? clr_idx : clr_idx + 1'b1) : (clr_req ? CLR_FIRST : clr_idx);
    end
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state <= IDLE;
            clr_idx <= '0;
            wr_ack <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            state <= state_n;
            clr_idx <= clr_idx_n;
            wr_ack <= accept;
            clr_done <= clr_busy && last;
        end
    for (genvar i = 0; i < NUM_REGS; i++) begin : g
        assign wr_hot[i] = accept && wr_sel == SEL_W'(i);
        assign clr_hot[i] = clr_busy && clr_idx == SEL_W'(i);
        if (R0_ZERO && i == 0) begin : z
            assign regs_flat[REG_W-1:0] = '0;
        end else begin : r
            reg_load32 u_reg (
                .clock(clock),
                .reset(reset),
                .load(ld[i]),
                .d(ld_data),
                .q(regs_flat[i*REG_W +: REG_W])
            );
        end
    end
endmodule

// File: tb/tb_bus_reg_bank.sv
// tb_bus_reg_bank: directed stimulus against a register-array model of the bus register bank.
module tb_bus_reg_bank;
`ifdef BUS_REG_BANK_R0_ZERO_EN
    localparam bit R0Z = 1'b1;
    localparam int NCLR = 31;
`else
    localparam bit R0Z = 1'b0;
    localparam int NCLR = 32;
`endif
    logic clock = 1'b0, reset = 1'b1, wr_en = 1'b0, clr_req = 1'b0;
    logic [4:0] wr_sel = '0;
    logic [31:0] wr_data = '0;
    logic wr_ready, wr_ack, clr_busy, clr_done;
    logic [1023:0] regs_flat;
    int checks = 0, errors = 0;
    bit go = 0;

    bus_reg_bank dut (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .wr_ready(wr_ready), .wr_ack(wr_ack), .clr_req(clr_req), .clr_busy(clr_busy),
        .clr_done(clr_done), .regs_flat(regs_flat)
    );

    always #5 clock = ~clock;

    logic [31:0] m_regs [32];
    bit m_busy, m_ack, m_done;
    int m_left, m_next;

    always @(posedge clock or posedge reset)
        if (reset) begin
            foreach (m_regs[k]) m_regs[k] = '0;
            m_busy = 0; m_ack = 0; m_done = 0; m_left = 0; m_next = 0;
        end else begin
            m_ack = wr_en && !m_busy;
            m_done = 0;
            if (m_busy) begin
                m_regs[m_next] = '0;
                m_next++;
                m_left--;
                if (m_left == 0) begin m_busy = 0; m_done = 1; end
            end else begin
                if (wr_en && !(R0Z && wr_sel == 0)) m_regs[wr_sel] = wr_data;
                if (clr_req) begin m_busy = 1; m_left = NCLR; m_next = R0Z ? 1 : 0; end
            end
        end

    task automatic chk(input string name, input logic [1023:0] got, input logic [1023:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    function automatic logic [1023:0] model_flat();
        logic [1023:0] f;
        for (int k = 0; k < 32; k++) f[k*32 +: 32] = m_regs[k];
        return f;
    endfunction

    always @(posedge clock) begin
        #2;
        if (go && !reset) begin
            chk("regs", regs_flat, model_flat());
            chk("wr_ack", 1024'(wr_ack), 1024'(m_ack));
            chk("clr_busy", 1024'(clr_busy), 1024'(m_busy));
            chk("clr_done", 1024'(clr_done), 1024'(m_done));
            chk("wr_ready", 1024'(wr_ready), 1024'(!m_busy));
        end
    end

    task automatic wait_idle(input string name, output int cnt);
        cnt = 0;
        while (clr_busy && cnt < 200) begin cnt++; @(negedge clock); end
        if (clr_busy) chk({name, "_timeout"}, 1024'(clr_busy), 1024'(0));
    endtask

    initial begin
        logic [1023:0] e;
        int n;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        go = 1;
        #1;
        chk("rst_regs", regs_flat, '0);
        chk("rst_flags", {wr_ready, wr_ack, clr_busy, clr_done}, 1024'(4'b1000));
        @(negedge clock);
        wr_en = 1; wr_sel = 5; wr_data = 32'hDEADBEEF;
        @(negedge clock);
        wr_en = 0;
        chk("w5_val", 1024'(regs_flat[191:160]), 1024'(32'hDEADBEEF));
        chk("w5_ack", 1024'(wr_ack), 1024'(1));
        e = '0; e[191:160] = 32'hDEADBEEF;
        chk("w5_others", regs_flat, e);
        for (int i = 0; i < 32; i++) begin
            @(negedge clock);
            wr_en = 1; wr_sel = 5'(i); wr_data = 32'h100 + i;
        end
        @(negedge clock);
        wr_en = 0;
        chk("fill_r31", 1024'(regs_flat[1023:992]), 1024'(32'h11F));
        chk("fill_r0", 1024'(regs_flat[31:0]), 1024'(R0Z ? 32'h0 : 32'h100));
        clr_req = 1;
        @(negedge clock);
        clr_req = 0; wr_en = 1; wr_sel = 7; wr_data = 32'hA5A5_0007;
        chk("clr_ready_low", 1024'(wr_ready), 1024'(0));
        wait_idle("clr1", n);
        chk("clr1_done", 1024'(clr_done), 1024'(1));
        @(negedge clock);
        wr_en = 0;
        chk("clr1_len", 1024'(n), 1024'(NCLR));
        e = '0; e[7*32 +: 32] = 32'hA5A5_0007;
        chk("clr1_regs", regs_flat, e);
        @(negedge clock);
        clr_req = 1; wr_en = 1; wr_sel = 3; wr_data = 32'h55;
        @(negedge clock);
        clr_req = 0; wr_en = 0;
        chk("cw_r3", 1024'(regs_flat[127:96]), 1024'(32'h55));
        wait_idle("clr2", n);
        chk("cw_r3_zero", 1024'(regs_flat[127:96]), 1024'(0));
        chk("clr2_len", 1024'(n), 1024'(NCLR));
        @(negedge clock);
        clr_req = 1;
        @(negedge clock);
        clr_req = 0;
        repeat (10) @(negedge clock);
        reset = 1;
        #1;
        chk("mid_rst_regs", regs_flat, '0);
        chk("mid_rst_flags", {wr_ready, wr_ack, clr_busy, clr_done}, 1024'(4'b1000));
        @(negedge clock);
        reset = 0; wr_en = 1; wr_sel = 9; wr_data = 32'h1234;
        @(negedge clock);
        wr_en = 0;
        chk("post_rst_ack", 1024'(wr_ack), 1024'(1));
        chk("post_rst_r9", 1024'(regs_flat[319:288]), 1024'(32'h1234));
        @(negedge clock);
        wr_en = 1; wr_sel = 0; wr_data = 32'hFFFFFFFF;
        @(negedge clock);
        wr_en = 0;
        chk("r0_ack", 1024'(wr_ack), 1024'(1));
        chk("r0_val", 1024'(regs_flat[31:0]), 1024'(R0Z ? 32'h0 : 32'hFFFFFFFF));
        repeat (3) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
